// File: rtl/wavetable_writer.sv
// wavetable_writer: receives framed waveform uploads from the byte stream,
// stages the samples locally and commits them into the sample RAM write
// port only after the frame checksum matches. Corrupt, malformed or stalled
// frames are dropped without ever touching the playing wavetable.
module wavetable_writer #(
  parameter int         SAMPLES_PER_WFM = 64,
  parameter int         PROG_W          = 7,
  parameter logic [7:0] SYNC_BYTE       = 8'hF0,
  parameter int         TIMEOUT         = 65535
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [7:0]                                  in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic                                        wr_en,
  output logic [PROG_W+$clog2(SAMPLES_PER_WFM)-1:0]   wr_addr,
  output logic [7:0]                                  wr_data,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  output logic [1:0]                                  err_code
);

  localparam int SMP_W = $clog2(SAMPLES_PER_WFM);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [SMP_W-1:0] IDX_LAST = SMP_W'(SAMPLES_PER_WFM - 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);

  localparam logic [1:0] ERR_PROG    = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_DATA,
    S_CSUM,
    S_COMMIT
  } state_e;

  state_e                    state_q, state_d;
  logic [PROG_W-1:0]         prog_q, prog_d;
  logic [7:0]                sum_q, sum_d;
  logic [SMP_W-1:0]          idx_q, idx_d;
  logic [TMO_W-1:0]          idleCnt_q, idleCnt_d;
  logic                      inReady_q, inReady_d;
  logic                      wrEn_q, wrEn_d;
  logic [PROG_W+SMP_W-1:0]   wrAddr_q, wrAddr_d;
  logic [7:0]                wrData_q, wrData_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [1:0]                errCode_q, errCode_d;

  logic [7:0]                stage_q [SAMPLES_PER_WFM];
  logic                      stageWe;

  logic                      accept;
  logic                      timedOut;
  logic [SMP_W-1:0]          idxInc;
  logic [TMO_W-1:0]          idleInc;

  // idleCnt_q is the number of cycles elapsed since the last accepted byte,
  // so it restarts at 1 and the timeout fires when it would reach TIMEOUT.
  always_comb begin
    accept    = in_valid & inReady_q;
    idxInc    = idx_q + SMP_W'(1);
    idleInc   = idleCnt_q + TMO_W'(1);
    timedOut  = 1'b0;

    state_d   = state_q;
    prog_d    = prog_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    idleCnt_d = TMO_W'(1);
    wrEn_d    = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    errCode_d = errCode_q;
    stageWe   = 1'b0;

    if ((state_q == S_PROG) || (state_q == S_DATA) || (state_q == S_CSUM)) begin
      if (!accept) begin
        idleCnt_d = idleInc;
        timedOut  = (idleInc == TMO_LIM);
      end
    end

    if (timedOut) begin
      err_d     = 1'b1;
      errCode_d = ERR_TIMEOUT;
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            state_d = S_PROG;
          end
        end
        S_PROG: begin
          if (accept) begin
            if (in_data[7]) begin
              err_d     = 1'b1;
              errCode_d = ERR_PROG;
              state_d   = S_IDLE;
            end else begin
              prog_d  = in_data[PROG_W-1:0];
              sum_d   = in_data;
              idx_d   = '0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            stageWe = 1'b1;
            sum_d   = sum_q + in_data;
            idx_d   = idxInc;
            if (idx_q == IDX_LAST) begin
              state_d = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == sum_q) begin
              idx_d    = '0;
              wrEn_d   = 1'b1;
              wrAddr_d = {prog_q, {SMP_W{1'b0}}};
              wrData_d = stage_q[0];
              state_d  = S_COMMIT;
            end else begin
              err_d     = 1'b1;
              errCode_d = ERR_CSUM;
              state_d   = S_IDLE;
            end
          end
        end
        S_COMMIT: begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d    = idxInc;
            wrEn_d   = 1'b1;
            wrAddr_d = {prog_q, idxInc};
            wrData_d = stage_q[idxInc];
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    inReady_d = (state_d != S_COMMIT);
    busy_d    = (state_d != S_IDLE);
  end

  // State, frame bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prog_q    <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      idleCnt_q <= TMO_W'(1);
      inReady_q <= 1'b0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      errCode_q <= '0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      idleCnt_q <= idleCnt_d;
      inReady_q <= inReady_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
    end
  end

  // Staging buffer holds the current frame's samples; no reset needed.
  always_ff @(posedge clk) begin
    if (stageWe) begin
      stage_q[idx_q] <= in_data;
    end
  end

  assign in_ready = inReady_q;
  assign wr_en    = wrEn_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = errCode_q;

endmodule
